pipe_skid_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_sat_counter.sv | 26 ++
 rtl/pipe_skid_stage.sv | 158 +++++++++++++++
 tb/tb_pipe_skid_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the pipeline skid stage.
//   ST_EMPTY / ST_ONE / ST_TWO : state encoding {skidV, mainV}
//   PIPE_CNT_W                 : default bubble counter width
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b11;

  localparam int PIPE_CNT_W = 32;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk   in        clock
//   rst   in        synchronous active-high clear
//   inc   in        count enable
//   count out CNT_W current value
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != CntMax)) begin
      count <= count + CntOne;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, local stall/flush and a saturating bubble counter.
//   clk, rst            clock, synchronous active-high reset
//   flushE              drop everything held in the stage
//   stallE              freeze: no accept, no emit
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data = main register
//   bubble_cnt          count of empty, unstalled, unflushed cycles
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 256,
  parameter int SKID       = 1,
  parameter int FLUSH_ZERO = 1,
  parameter int CNT_W      = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flushE,
  input  logic             stallE,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [1:0]       stateReg;
  logic [1:0]       stateNext;
  logic [WIDTH-1:0] mainDataReg;
  logic [WIDTH-1:0] mainDataNext;
  logic             mainV;
  logic             accept;
  logic             fire;

  assign mainV  = stateReg[0];
  assign accept = in_valid & in_ready;
  // fire is only meaningful when flush is low; the next-state logic gives
  // flush priority over it.
  assign fire   = mainV & out_ready & ~stallE;

  // State register and the main payload register, shared by both variants.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= ST_EMPTY;
      mainDataReg <= '0;
    end else begin
      stateReg    <= stateNext;
      mainDataReg <= mainDataNext;
    end
  end

  // Outputs seen by the downstream stage.
  always_comb begin
    out_valid = mainV & ~stallE;
    out_data  = mainDataReg;
  end

  generate
    if (SKID != 0) begin : gSkid
      logic [WIDTH-1:0] skidDataReg;
      logic [WIDTH-1:0] skidDataNext;
      logic             skidV;

      assign skidV = stateReg[1];
      // Depends only on the skid flag and the control inputs, never on
      // out_ready, so the ready path is cut between stages.
      assign in_ready = ~skidV & ~stallE & ~rst & ~flushE;

      always_comb begin
        stateNext    = stateReg;
        mainDataNext = mainDataReg;
        skidDataNext = skidDataReg;
        if (flushE) begin
          stateNext = ST_EMPTY;
          if (FLUSH_ZERO != 0) begin
            mainDataNext = '0;
            skidDataNext = '0;
          end
        end else if (!stallE) begin
          case (stateReg)
            ST_EMPTY: begin
              if (accept) begin
                stateNext    = ST_ONE;
                mainDataNext = in_data;
              end
            end
            ST_ONE: begin
              if (accept && !fire) begin
                stateNext    = ST_TWO;
                skidDataNext = in_data;
              end else if (fire && !accept) begin
                stateNext = ST_EMPTY;
              end else if (fire && accept) begin
                mainDataNext = in_data;
              end
            end
            ST_TWO: begin
              // in_ready is low here, so only the drain can happen.
              if (fire) begin
                stateNext    = ST_ONE;
                mainDataNext = skidDataReg;
              end
            end
            default: stateNext = ST_EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          skidDataReg <= '0;
        end else begin
          skidDataReg <= skidDataNext;
        end
      end
    end else begin : gNoSkid
      // Single entry: a full stage can still take a new word when the
      // downstream drains the current one in the same cycle.
      assign in_ready = ~stallE & ~rst & ~flushE & (~mainV | out_ready);

      always_comb begin
        stateNext    = stateReg;
        mainDataNext = mainDataReg;
        if (flushE) begin
          stateNext = ST_EMPTY;
          if (FLUSH_ZERO != 0) begin
            mainDataNext = '0;
          end
        end else if (!stallE) begin
          case (stateReg)
            ST_EMPTY, ST_ONE: begin
              if (accept) begin
                stateNext    = ST_ONE;
                mainDataNext = in_data;
              end else if (fire) begin
                stateNext = ST_EMPTY;
              end
            end
            default: stateNext = ST_EMPTY;
          endcase
        end
      end
    end
  endgenerate

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) uBubbleCnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (~rst & ~flushE & ~stallE & ~mainV),
    .count(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int W = 16;
  localparam logic [31:0] NoEntry = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: SKID=1, FLUSH_ZERO=1, 4-bit counter
  logic          flushA = 1'b0, stallA = 1'b0;
  logic          inValidA = 1'b0, outReadyA = 1'b0;
  logic [W-1:0]  inDataA = '0;
  logic          inReadyA, outValidA;
  logic [W-1:0]  outDataA;
  logic [3:0]    bubbleA;

  // Instance B: SKID=0
  logic          flushB = 1'b0, stallB = 1'b0;
  logic          inValidB = 1'b0, outReadyB = 1'b0;
  logic [W-1:0]  inDataB = '0;
  logic          inReadyB, outValidB;
  logic [W-1:0]  outDataB;
  logic [7:0]    bubbleB;

  int nVec = 0;
  int nMis = 0;

  logic [31:0] qA[$];
  logic [31:0] qB[$];
  logic [31:0] expA, expB;
  int pushedB = 0, poppedB = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(W), .SKID(1), .FLUSH_ZERO(1), .CNT_W(4)) dutA (
    .clk(clk), .rst(rst), .flushE(flushA), .stallE(stallA),
    .in_valid(inValidA), .in_ready(inReadyA), .in_data(inDataA),
    .out_valid(outValidA), .out_ready(outReadyA), .out_data(outDataA),
    .bubble_cnt(bubbleA)
  );

  pipe_skid_stage #(.WIDTH(W), .SKID(0), .FLUSH_ZERO(1), .CNT_W(8)) dutB (
    .clk(clk), .rst(rst), .flushE(flushB), .stallE(stallB),
    .in_valid(inValidB), .in_ready(inReadyB), .in_data(inDataB),
    .out_valid(outValidB), .out_ready(outReadyB), .out_data(outDataB),
    .bubble_cnt(bubbleB)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drainA(input int budget);
    int n = 0;
    while (qA.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drainA", qA.size(), 0);
  endtask

  // Scoreboards: sample the handshake mid-cycle; an entry transferred at the
  // coming edge is compared/pushed here. Flush and reset kill held entries.
  always @(negedge clk) begin
    if (rst || flushA) begin
      qA.delete();
    end else begin
      if (outValidA && outReadyA) begin
        expA = (qA.size() > 0) ? qA.pop_front() : NoEntry;
        chk("outA", {16'h0, outDataA}, expA);
      end
      if (inValidA && inReadyA) qA.push_back({16'h0, inDataA});
    end
    if (rst || flushB) begin
      qB.delete();
    end else begin
      if (outValidB && outReadyB) begin
        expB = (qB.size() > 0) ? qB.pop_front() : NoEntry;
        chk("outB", {16'h0, outDataB}, expB);
        poppedB++;
      end
      if (inValidB && inReadyB) begin
        qB.push_back({16'h0, inDataB});
        pushedB++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic modelFull;
    logic expIr;
    int   n;

    // ---------------- reset state ----------------
    rst = 1'b1;
    tick(); tick();
    chk("rstInReady", inReadyA, 0);
    chk("rstOutValid", outValidA, 0);
    chk("rstOutData", outDataA, 0);
    chk("rstBubble", bubbleA, 0);

    // ---------------- stream 1..8 ----------------
    rst = 1'b0; outReadyA = 1'b1; inValidA = 1'b1; inDataA = 16'd1;
    #1;
    chk("inReadyPostRst", inReadyA, 1);
    for (int i = 2; i <= 9; i++) begin
      tick();
      if (i <= 8) inDataA = W'(i);
      else inValidA = 1'b0;
      #1;
      chk("streamValid", outValidA, 1);
      chk("streamData", outDataA, i - 1);
    end
    chk("bubbleStream", bubbleA, 1);
    drainA(10);

    // ---------------- back-pressure A,B,C ----------------
    rst = 1'b1; tick(); rst = 1'b0;
    outReadyA = 1'b0; inValidA = 1'b1; inDataA = 16'h00A1;
    #1; chk("bpReadyA", inReadyA, 1);
    tick(); inDataA = 16'h00B2;
    #1; chk("bpReadyB", inReadyA, 1);
    tick(); inDataA = 16'h00C3;
    #1; chk("bpReadyTwo", inReadyA, 0);
    tick(); tick();
    #1; chk("bpHeldReady", inReadyA, 0);
    chk("bpHeadA", outDataA, 16'h00A1);
    outReadyA = 1'b1;
    n = 0;
    #1;
    while (!inReadyA && n < 10) begin
      tick(); n++;
    end
    chk("bpReopen", inReadyA, 1);
    tick(); inValidA = 1'b0;
    drainA(10);

    // ---------------- flush in TWO ----------------
    rst = 1'b1; tick(); rst = 1'b0;
    outReadyA = 1'b0; inValidA = 1'b1; inDataA = 16'h0011;
    tick(); inDataA = 16'h0022;
    tick(); inDataA = 16'h0077; flushA = 1'b1;
    tick(); flushA = 1'b0; inValidA = 1'b0;
    #1;
    chk("flushValid", outValidA, 0);
    chk("flushData", outDataA, 0);
    outReadyA = 1'b1;
    tick(); tick(); tick();
    chk("flushStillEmpty", outValidA, 0);
    chk("flushQueue", qA.size(), 0);

    // ---------------- stall in ONE ----------------
    rst = 1'b1; tick(); rst = 1'b0;
    outReadyA = 1'b0; inValidA = 1'b1; inDataA = 16'h00AA;
    tick();
    inDataA = 16'h00BB; stallA = 1'b1; outReadyA = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stallOutValid", outValidA, 0);
      chk("stallInReady", inReadyA, 0);
      tick();
    end
    chk("stallBubble", bubbleA, 1);
    stallA = 1'b0; inValidA = 1'b0;
    #1;
    chk("unstallValid", outValidA, 1);
    chk("unstallData", outDataA, 16'h00AA);
    tick();
    chk("afterStallEmpty", outValidA, 0);
    chk("stallQueue", qA.size(), 0);

    // ---------------- SKID=0 toggling out_ready ----------------
    rst = 1'b1; tick(); rst = 1'b0;
    inValidB = 1'b1; modelFull = 1'b0;
    for (int i = 0; i < 12; i++) begin
      outReadyB = (i % 2 == 0);
      inDataB = W'(16'h0100 + i);
      #1;
      expIr = ~modelFull | outReadyB;
      chk("inReadyB", inReadyB, expIr);
      if (inValidB && expIr) modelFull = 1'b1;
      else if (modelFull && outReadyB) modelFull = 1'b0;
      tick();
    end
    inValidB = 1'b0; outReadyB = 1'b1;
    n = 0;
    while (qB.size() > 0 && n < 10) begin
      tick(); n++;
    end
    chk("drainB", qB.size(), 0);
    chk("onceB", poppedB, pushedB);

    // ---------------- counter saturation ----------------
    rst = 1'b1; tick(); rst = 1'b0;
    inValidA = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) chk("satReach", bubbleA, 15);
    end
    chk("satHold", bubbleA, 15);
    rst = 1'b1; tick();
    chk("satClear", bubbleA, 0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
